uart_rx_param: RTL and testbench

Parametrised UART receiver and successor to the fixed 8N1 receiver. Supports configurable data width, parity, stop-bit count and oversampling ratio. Output is a registered valid/ready word with per-word frame and parity error flags, plus overrun detection. Sits between the FPGA rx pin and command parser / FIFO logic.

---
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data bits, parity, stop bits and oversampling,
// registered valid/ready output with frame/parity/overrun flags. Optional macro UART_RX_MAJORITY_EN.
module uart_rx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int BI_W  = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    // Decisions wait one extra tick so the vote window is centred on the nominal point.
    localparam int START_PT = OVERSAMPLE / 2;
`else
    localparam int START_PT = OVERSAMPLE / 2 - 1;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state, state_d;
    logic                 rx_m, rx_s, rx_d;
    logic [DIV_W-1:0]     div_cnt;
    logic [SC_W-1:0]      sample_cnt;
    logic [BI_W-1:0]      bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift_p0;
    logic                 frame_lat, par_err_lat;
    logic                 tick, fall, bit_val;
    logic                 at_start_pt, at_bit_pt, last_data, last_stop, complete;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    assign fall = rx_d & ~rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            div_cnt <= '0;
        else if (state == S_IDLE || div_cnt == DIV_W'(DIV - 1))
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (state != S_IDLE) && (div_cnt == DIV_W'(DIV - 1));

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    always_ff @(posedge clk) begin
        if (tick)
            hist <= {hist[0], rx_s};
    end
    assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
    assign bit_val = rx_s;
`endif

    assign at_start_pt = (sample_cnt == SC_W'(START_PT));
    assign at_bit_pt   = (sample_cnt == SC_W'(OVERSAMPLE - 1));
    assign last_data   = (bit_idx == BI_W'(DATA_BITS - 1));
    assign last_stop   = (stop_idx == 1'(STOP_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d  = state;
        complete = 1'b0;
        case (state)
            S_IDLE:   if (fall) state_d = S_START;
            S_START:  if (tick && at_start_pt) state_d = bit_val ? S_IDLE : S_DATA;
            S_DATA:   if (tick && at_bit_pt && last_data)
                          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (tick && at_bit_pt) state_d = S_STOP;
            S_STOP:   if (tick && at_bit_pt && last_stop) begin
                          state_d  = S_IDLE;
                          complete = 1'b1;
                      end
            default:  state_d = S_IDLE;
        endcase
    end

    // Bit counters and error latches, advanced on ticks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_cnt  <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            frame_lat   <= 1'b0;
            par_err_lat <= 1'b0;
        end else if (state == S_IDLE) begin
            sample_cnt  <= '0;
            bit_idx     <= '0;
            stop_idx    <= 1'b0;
            frame_lat   <= 1'b0;
            par_err_lat <= 1'b0;
        end else if (tick) begin
            if (state == S_START)
                sample_cnt <= at_start_pt ? '0 : sample_cnt + 1'b1;
            else
                sample_cnt <= at_bit_pt ? '0 : sample_cnt + 1'b1;
            if (at_bit_pt) begin
                case (state)
                    S_DATA:   bit_idx <= bit_idx + 1'b1;
                    S_PARITY: par_err_lat <= (((^shift_p0) ^ bit_val) != (PARITY == 1));
                    S_STOP: begin
                        frame_lat <= frame_lat | ~bit_val;
                        stop_idx  <= stop_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tick && at_bit_pt && state == S_DATA)
            shift_p0 <= {bit_val, shift_p0[DATA_BITS-1:1]};
    end

    // Output word register: loads on completion unless an unaccepted word is still held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (complete && (!data_valid || data_ready)) begin
                data_out   <= shift_p0;
                frame_err  <= frame_lat | ~bit_val;
                parity_err <= par_err_lat;
                data_valid <= 1'b1;
            end else begin
                if (complete)
                    overrun_err <= 1'b1;
                if (data_valid && data_ready)
                    data_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 default instance and a 7E2 instance.
module tb_uart_rx_param;

    localparam int BT = 27 * 16;

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx0 = 1'b1, rx1 = 1'b1;
    logic       ready0 = 1'b1, ready1 = 1'b1;
    logic [7:0] dout0;
    logic [6:0] dout1;
    logic       dv0, fe0, pe0, ovr0, busy0;
    logic       dv1, fe1, pe1, ovr1, busy1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   ovr_cnt0 = 0;
    int   ovr_cnt1 = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    uart_rx_param u_dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(dout0), .data_valid(dv0),
        .data_ready(ready0), .frame_err(fe0), .parity_err(pe0),
        .overrun_err(ovr0), .busy(busy0)
    );

    uart_rx_param #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(dout1), .data_valid(dv1),
        .data_ready(ready1), .frame_err(fe1), .parity_err(pe1),
        .overrun_err(ovr1), .busy(busy1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    // Line is left at the last stop-bit value when the task returns.
    task automatic send(input int which, input logic [8:0] d, input int nbits, input bit has_par,
                        input logic pbit, input int nstop, input logic stopv);
        set_rx(which, 1'b0);
        idle(BT);
        for (int i = 0; i < nbits; i++) begin
            set_rx(which, d[i]);
            idle(BT);
        end
        if (has_par) begin
            set_rx(which, pbit);
            idle(BT);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(which, stopv);
            idle(BT);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ovr0) ovr_cnt0++;
        if (ovr1) ovr_cnt1++;
        if (dv0 && ready0) begin
            if (q0.size() == 0) check("dut0_unexpected_word", {24'd0, dout0}, 32'hFFFF_FFFF);
            else begin
                e = q0.pop_front();
                check("dut0_data", {24'd0, dout0}, {23'd0, e.d});
                check("dut0_frame_err", {31'd0, fe0}, {31'd0, e.fe});
                check("dut0_parity_err", {31'd0, pe0}, {31'd0, e.pe});
            end
        end
        if (dv1 && ready1) begin
            if (q1.size() == 0) check("dut1_unexpected_word", {25'd0, dout1}, 32'hFFFF_FFFF);
            else begin
                e = q1.pop_front();
                check("dut1_data", {25'd0, dout1}, {23'd0, e.d});
                check("dut1_frame_err", {31'd0, fe1}, {31'd0, e.fe});
                check("dut1_parity_err", {31'd0, pe1}, {31'd0, e.pe});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_out0"}, {24'd0, dout0}, 32'd0);
        check({tag, "_valid0"}, {31'd0, dv0}, 32'd0);
        check({tag, "_frame_err0"}, {31'd0, fe0}, 32'd0);
        check({tag, "_parity_err0"}, {31'd0, pe0}, 32'd0);
        check({tag, "_overrun0"}, {31'd0, ovr0}, 32'd0);
        check({tag, "_busy0"}, {31'd0, busy0}, 32'd0);
        check({tag, "_valid1"}, {31'd0, dv1}, 32'd0);
        check({tag, "_busy1"}, {31'd0, busy1}, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(4);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 rst = 1'b1;
        idle(BT);

        // 0xA5 8N1, consumer always ready
        q0.push_back('{9'h0A5, 1'b0, 1'b0});
        send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(BT);
        @(negedge clk);
        check("a5_busy_after", {31'd0, busy0}, 32'd0);

        // Short low glitch is rejected at start validation
        rx0 = 1'b0;
        idle(27);
        @(negedge clk);
        check("glitch_busy_during", {31'd0, busy0}, 32'd1);
        idle(3 * 27 - 28);
        rx0 = 1'b1;
        idle(20 * 27);
        @(negedge clk);
        check("glitch_busy_after", {31'd0, busy0}, 32'd0);
        idle(BT);

        // 7E2: 0x35 has four ones, so even parity bit is 0; then flipped
        q1.push_back('{9'h035, 1'b0, 1'b0});
        send(1, 9'h035, 7, 1'b1, 1'b0, 2, 1'b1);
        idle(BT);
        q1.push_back('{9'h035, 1'b0, 1'b1});
        send(1, 9'h035, 7, 1'b1, 1'b1, 2, 1'b1);
        idle(BT);

        // Stop bit low, then a break of two frames, then a clean word
        q0.push_back('{9'h03C, 1'b1, 1'b0});
        send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
        idle(20 * BT);
        @(negedge clk);
        check("break_busy", {31'd0, busy0}, 32'd0);
        rx0 = 1'b1;
        idle(2 * BT);
        q0.push_back('{9'h011, 1'b0, 1'b0});
        send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(BT);

        // Overrun: consumer stalled across two back-to-back words
        @(posedge clk); #1 ready0 = 1'b0;
        q0.push_back('{9'h001, 1'b0, 1'b0});
        send(0, 9'h001, 8, 1'b0, 1'b0, 1, 1'b1);
        send(0, 9'h002, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(BT);
        @(negedge clk);
        check("ovr_held_data", {24'd0, dout0}, 32'h01);
        check("ovr_held_valid", {31'd0, dv0}, 32'd1);
        check("ovr_pulse_cycles", ovr_cnt0, 32'd1);
        @(posedge clk); #1 ready0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("valid_drop_after_accept", {31'd0, dv0}, 32'd0);
        idle(BT);

        // Reset in the middle of 0x55's data bits
        rx0 = 1'b0;
        idle(BT);
        for (int i = 0; i < 3; i++) begin
            rx0 = i[0] ? 1'b0 : 1'b1;
            idle(BT);
        end
        idle(BT / 2);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("midreset");
        rx0 = 1'b1;
        idle(10);
        @(negedge clk);
        check_zero_outputs("midreset_hold");
        @(posedge clk); #1 rst = 1'b1;
        idle(BT);
        q0.push_back('{9'h066, 1'b0, 1'b0});
        send(0, 9'h066, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(BT);

        check("dut0_missing_words", q0.size(), 32'd0);
        check("dut1_missing_words", q1.size(), 32'd0);
        check("dut0_overrun_total", ovr_cnt0, 32'd1);
        check("dut1_overrun_total", ovr_cnt1, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
